// File: rtl/param_sum_accumulator_if.sv
// Beat and result handshakes of the sum accumulator.
// The slave modport is the accumulator; the master modport is the upstream/sink side.
interface param_sum_accumulator_if #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_s;
  logic                 in_cout;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic                 out_ovf;

  modport master (
    output in_valid, in_s, in_cout, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_s, in_cout, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/param_sum_accumulator.sv
// Sums COUNT consecutive {cout,s} beats into an ACC_WIDTH total with a sticky carry-out flag,
// then holds the result until the sink takes it.
module param_sum_accumulator #(
  parameter int WIDTH     = 4,
  parameter int COUNT     = 4,
  parameter int ACC_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  param_sum_accumulator_if.slave        bus,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);
  // Both handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready and out_valid depend only on registered state, never on the partner's signals.
  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 accept;
  logic [ACC_WIDTH:0]   beat_ext;
  logic [ACC_WIDTH:0]   sum_ext;

  always_comb begin
    beat_ext          = '0;
    beat_ext[WIDTH:0] = {bus.in_cout, bus.in_s};
    sum_ext           = {1'b0, acc_q} + beat_ext;
    accept            = bus.in_valid && (state_q != S_HOLD);
    state_d           = state_q;
    acc_d             = acc_q;
    ovf_d             = ovf_q;
    cnt_d             = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d   = beat_ext[ACC_WIDTH-1:0];
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(1);
          state_d = (COUNT == 1) ? S_HOLD : S_ACC;
        end
      end
      S_ACC: begin
        if (accept) begin
          acc_d = sum_ext[ACC_WIDTH-1:0];
          ovf_d = ovf_q | sum_ext[ACC_WIDTH];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort drops any beat offered in the same cycle, so acc/ovf keep their old values.
    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q != S_HOLD);
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.out_sum   = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign busy          = (state_q != S_IDLE);
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_param_sum_accumulator.sv
// Randomized and directed bench for param_sum_accumulator; an 8-bit and a 6-bit accumulator
// share one stimulus stream and are checked against a beat-queue reference model.
module tb_param_sum_accumulator;
  localparam int WIDTH = 4;
  localparam int COUNT = 4;
  localparam int AW    = 8;
  localparam int AW6   = 6;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       busy, busy6;
  logic [1:0] dbg_state, dbg_state6;

  param_sum_accumulator_if #(.WIDTH(WIDTH), .ACC_WIDTH(AW))  bus ();
  param_sum_accumulator_if #(.WIDTH(WIDTH), .ACC_WIDTH(AW6)) bus6 ();

  assign bus6.in_valid  = bus.in_valid;
  assign bus6.in_s      = bus.in_s;
  assign bus6.in_cout   = bus.in_cout;
  assign bus6.out_ready = bus.out_ready;

  param_sum_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT), .ACC_WIDTH(AW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  param_sum_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT), .ACC_WIDTH(AW6)) u_dut6 (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .bus       (bus6),
    .busy      (busy6),
    .dbg_state (dbg_state6)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: accepted beats of the open burst, expected results {ovf6,sum6,ovf8,sum8}
  int          n_checks = 0;
  int          n_fail   = 0;
  int          beats[$];
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, check, then update the model at the rising edge.
  task automatic cycle(input bit v, input logic [4:0] beat, input bit ordy, input bit clr, input bit r);
    int          total;
    logic [15:0] e;
    bus.in_valid            = v;
    {bus.in_cout, bus.in_s} = beat;
    bus.out_ready           = ordy;
    clear                   = clr;
    rst                     = r;
    #1;
    check_eq("in_ready", 32'(bus.in_ready), 32'(beats.size() < COUNT));
    check_eq("out_valid", 32'(bus.out_valid), 32'(beats.size() == COUNT));
    check_eq("out_valid6", 32'(bus6.out_valid), 32'(beats.size() == COUNT));
    check_eq("busy", 32'(busy), 32'(beats.size() != 0));
    if (beats.size() == COUNT && exp_q.size() > 0) begin
      e = exp_q[0];
      check_eq("out_sum", 32'(bus.out_sum), 32'(e[7:0]));
      check_eq("out_ovf", 32'(bus.out_ovf), 32'(e[8]));
      check_eq("out_sum6", 32'(bus6.out_sum), 32'(e[14:9]));
      check_eq("out_ovf6", 32'(bus6.out_ovf), 32'(e[15]));
    end
    @(posedge clk);
    if (r || clr) begin
      if (beats.size() == COUNT && exp_q.size() > 0) void'(exp_q.pop_front());
      beats.delete();
    end else if (beats.size() == COUNT) begin
      if (ordy) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        beats.delete();
      end
    end else if (v) begin
      beats.push_back(int'(beat));
      if (beats.size() == COUNT) begin
        total = 0;
        foreach (beats[i]) total += beats[i];
        e       = '0;
        e[7:0]  = 8'(total % 256);
        e[8]    = (total >= 256);
        e[14:9] = 6'(total % 64);
        e[15]   = (total >= 64);
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic burst(input logic [4:0] val, input bit ordy);
    for (int i = 0; i < COUNT; i++) cycle(1'b1, val, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    int bub[4];
    bub = '{7, 0, 1, 2};
    bus.in_valid  = 1'b0;
    bus.in_s      = '0;
    bus.in_cout   = 1'b0;
    bus.out_ready = 1'b1;
    clear         = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check_eq("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    rst = 1'b0;

    // back-to-back 1,2,3,4
    for (int i = 1; i <= 4; i++) cycle(1'b1, 5'(i), 1'b1, 1'b0, 1'b0);
    idle(2);
    // four 31s: 124 in 8 bits, 60 with carry in 6 bits
    burst(5'h1F, 1'b1);
    idle(2);
    // backpressure with in_valid held high
    burst(5'd3, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    idle(2);
    // bubbles between beats
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 5'(bub[i]), 1'b1, 1'b0, 1'b0);
      if (i < 3) idle($urandom_range(1, 3));
    end
    idle(2);
    // reset mid-burst, then a fresh burst of 5s
    cycle(1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    check_eq("midrst_out_sum", 32'(bus.out_sum), 32'd0);
    burst(5'd5, 1'b1);
    idle(2);
    // clear mid-burst with a beat offered on the clear cycle
    cycle(1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 5'd6, 1'b1, 1'b1, 1'b0);
    burst(5'd5, 1'b1);
    idle(2);
    // clear while holding a result
    burst(5'd8, 1'b0);
    cycle(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 79) == 0));
    end
    idle(COUNT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
